fifo_rd_streamer: RTL and testbench
===================================

# fifo_rd_streamer

Downstream drain stage for `fifo_memory`. It issues `mem_rd_en` pulses whenever the memory is non-empty and local buffer credit allows. It captures the registered read data one cycle later and presents it to the consumer as a valid/ready stream through a 3-entry skid buffer. Memory read errors are latched as a sticky error that halts reads until software clears it.

## Interface
Parameters:
- WIDTH, from FIFO_param_pkg (32): data word width.
- SKID_DEPTH, 3: skid buffer entries; must be ≥ 3 for full throughput.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- en  in  1  level; allows new memory reads.
- err_clr  in  1  single-cycle pulse; clears sticky error.
- mem_empty  in  1  memory empty flag.
- fifo_rd_data  in  WIDTH  memory read data; valid the cycle after `mem_rd_en`.
- mem_rd_err  in  1  memory read error; aligned with `fifo_rd_data`.
- mem_rd_en  out  1  read request to memory.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  stream word.
- rd_err  out  1  sticky error flag.
- word_count  out  16  words delivered; present only with FIFO_RD_STATS_EN.

## Operation
- States: IDLE, RUN, ERR. Reset state: IDLE.
- State transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0.
  - RUN→ERR when a response cycle has `mem_rd_err`=1.
  - ERR→IDLE on `err_clr`. `err_clr` has priority over `en`. `err_clr` outside ERR is ignored.
- `mem_rd_en` = (state==RUN) && !mem_empty && (occ + inflight < SKID_DEPTH).
  - Combinational from registered state only.
  - No path from `out_ready`.
- `inflight` is a 1-bit register: set the cycle after `mem_rd_en`=1, clear otherwise.
- Response cycle (`inflight`=1):
  - `mem_rd_err`=0: push `fifo_rd_data` into the skid buffer.
  - `mem_rd_err`=1: discard the data, set `rd_err`, go to ERR.
- A response already in flight when leaving RUN (en drop) is still captured.
- Skid buffer:
  - Circular, rd/wr pointers wrap at SKID_DEPTH-1→0.
  - `occ` ranges 0..SKID_DEPTH.
  - Push and pop in the same cycle leave `occ` unchanged.
  - Overflow is impossible by the credit rule; the bench asserts it.
- Output:
  - `out_valid` = (occ != 0).
  - `out_data` = head entry. Held stable while `out_valid` && !`out_ready`.
  - Pop on `out_valid` && `out_ready`.
- ERR: no new reads. Buffered words continue to drain to the consumer.
- Reset mid-operation: buffer contents, in-flight response, and error are all lost.
- Output reset values: `mem_rd_en` 0, `out_valid` 0, `out_data` 0, `rd_err` 0, `word_count` 0.

## Timing
- `mem_rd_en` high in cycle t → data sampled at the end of t+1 → `out_valid` high in t+2.
- Read-to-output latency: 2 cycles.
- Throughput: 1 word/cycle sustained when `out_ready`=1 and the memory stays non-empty.
- `out_ready` low stops reads once occ + inflight = SKID_DEPTH:
  - at most 1 further read is issued after the stall starts;
  - no data is lost.
- `rd_err` rises in t+2 after the erroring read in t.
- `rd_err` falls the cycle after the `err_clr` pulse.
- `mem_empty` is trusted as sampled in the same cycle.

## Configuration
- FIFO_RD_STATS_EN defined:
  - `word_count` port exists.
  - It increments by 1 per pop and wraps at 16'hFFFF→0.
  - It is cleared only by reset.
- FIFO_RD_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- FIFO_param_pkg gets:
  - `SKID_DEPTH`;
  - `typedef enum logic [1:0] {IDLE, RUN, ERR} rd_state_t`;
  - `typedef logic [WIDTH-1:0] word_t`.
- Sub-module `fifo_skid_buf`: parameterized circular buffer with push/pop/occ/head. The FSM, credit logic, and error logic stay in the top level.

## Test plan
- Reset with `en`=1, then memory preloaded with 5 words 0xA0..0xA4 and `out_ready`=1:
  - first `mem_rd_en` in cycle 1 after reset release;
  - `out_data` 0xA0..0xA4 on 5 consecutive cycles from cycle 3;
  - no bubbles.
- `out_ready`=0 with 8 words available:
  - `mem_rd_en` stops after 3 reads;
  - occ=3, `out_data` holds 0xA0;
  - releasing `out_ready` delivers all 8 in order.
- `mem_rd_err`=1 on the 2nd response:
  - 1st word delivered, 2nd dropped;
  - `rd_err`=1 and no further `mem_rd_en`;
  - `err_clr` returns to IDLE and reads resume with the 3rd word.
- `en` dropped in the same cycle as a `mem_rd_en`: that word is still delivered, then no more reads.
- Reset asserted with occ=2 and a read in flight: all outputs 0 immediately; nothing delivered after reset release.
- With FIFO_RD_STATS_EN: deliver 0x10001 words → `word_count`=1.

Source files
------------

// File: rtl/FIFO_param_pkg.sv
// Shared parameters and types for the FIFO read path.
package FIFO_param_pkg;

    localparam int WIDTH      = 32;
    localparam int SKID_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } rd_state_t;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Circular skid buffer: push at the tail, pop at the head, occupancy 0..DEPTH.
// Head data comes straight from the storage flops so it stays stable while held.
module fifo_skid_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OW-1:0]    occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             push_ok_s, pop_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] nxt;
        if (p == PW'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = p + PW'(1);
        end
        return nxt;
    endfunction

    // A full buffer only accepts a push when a pop frees a slot in the same cycle.
    assign pop_ok_s  = pop && (occ_q != '0);
    assign push_ok_s = push && ((occ_q != OW'(DEPTH)) || pop_ok_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Buffer state flops; reset clears contents so the head reads zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains fifo_memory into a valid/ready stream through a credit-controlled skid buffer.
// Optional FIFO_RD_STATS_EN adds a 16-bit delivered-word counter output.
module fifo_rd_streamer #(
    parameter int WIDTH      = FIFO_param_pkg::WIDTH,
    parameter int SKID_DEPTH = FIFO_param_pkg::SKID_DEPTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             err_clr,
    input  logic             mem_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             mem_rd_err,
    output logic             mem_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             rd_err
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      word_count
`endif
);

    import FIFO_param_pkg::*;

    localparam int OW = $clog2(SKID_DEPTH + 1);

    rd_state_t     state_q, state_d;
    logic          inflight_q, inflight_d;
    logic          rd_err_q, rd_err_d;
    logic [OW-1:0] occ_s;
    logic [OW:0]   credit_used_s;
    logic          push_s, pop_s, resp_err_s;

    // Credit counts buffered words plus the response still on its way back.
    assign credit_used_s = {1'b0, occ_s} + {{OW{1'b0}}, inflight_q};
    assign mem_rd_en     = (state_q == RUN) && !mem_empty
                           && (credit_used_s < (OW + 1)'(SKID_DEPTH));

    assign push_s     = inflight_q && !mem_rd_err;
    assign resp_err_s = inflight_q && mem_rd_err;
    assign out_valid  = (occ_s != '0);
    assign pop_s      = out_valid && out_ready;
    assign rd_err     = rd_err_q;

    fifo_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (push_s),
        .push_data (fifo_rd_data),
        .pop       (pop_s),
        .occ       (occ_s),
        .head      (out_data)
    );

    // Control next-state; an erroring response wins over any other transition.
    always_comb begin
        state_d    = state_q;
        rd_err_d   = rd_err_q;
        inflight_d = mem_rd_en;
        if (resp_err_s) begin
            state_d  = ERR;
            rd_err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state_d  = IDLE;
                        rd_err_d = 1'b0;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    rd_err_d = 1'b0;
                end
            endcase
        end
    end

    // Control flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            rd_err_q   <= rd_err_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_count_q, word_count_d;

    // Delivered-word counter, wraps naturally at 16 bits.
    always_comb begin
        if (pop_s) begin
            word_count_d = word_count_q + 16'd1;
        end else begin
            word_count_d = word_count_q;
        end
    end

    // Counter flop, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            word_count_q <= 16'd0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: cycle tables plus hand sequences and a memory model.
module tb_fifo_rd_streamer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        en = 1'b0;
    logic        err_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic        mem_empty;
    logic        mem_rd_err = 1'b0;
    logic [31:0] fifo_rd_data = 32'h0;
    logic        mem_rd_en, out_valid, rd_err;
    logic [31:0] out_data;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_count;
`endif

    int total = 0;
    int bad   = 0;
    int rd_idx = 0, wr_idx = 0, seg_start = 0, err_at = -1, drops_n = 0;
    int reads_n = 0, pops_n = 0, drops_base = 0;

    typedef struct {
        logic        rst;
        int          pre;
        int          err_k;
        logic        en;
        logic        rdy;
        logic        clr;
        logic        x_rd_en;
        logic        x_valid;
        logic [31:0] x_data;
        logic        x_err;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    fifo_rd_streamer dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .en           (en),
        .err_clr      (err_clr),
        .mem_empty    (mem_empty),
        .fifo_rd_data (fifo_rd_data),
        .mem_rd_err   (mem_rd_err),
        .mem_rd_en    (mem_rd_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .rd_err       (rd_err)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_count   (word_count)
`endif
    );

    // Memory model: word k of a segment reads as 0xA0+k, one cycle after mem_rd_en.
    assign mem_empty = (rd_idx >= wr_idx);

    always @(posedge CLK) begin
        if (mem_rd_en) begin
            fifo_rd_data <= 32'hA0 + 32'(rd_idx - seg_start);
            mem_rd_err   <= (rd_idx == err_at);
            if (rd_idx == err_at) drops_n <= drops_n + 1;
            rd_idx <= rd_idx + 1;
        end else begin
            mem_rd_err <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic en_i, input logic rdy_i, input logic clr_i);
        int outstanding;
        @(posedge CLK);
        #1;
        en = en_i;
        out_ready = rdy_i;
        err_clr = clr_i;
        #1;
        if (mem_rd_en) reads_n++;
        if (out_valid && out_ready) pops_n++;
        outstanding = reads_n - pops_n - (drops_n - drops_base);
        check("no_overflow", {31'd0, outstanding <= 3}, 32'd1);
    endtask

    task automatic do_reset(input logic en_v, input logic rdy_v, input int pre, input int err_k);
        nRST = 1'b0;
        en = en_v;
        out_ready = rdy_v;
        err_clr = 1'b0;
        #1;
        check("rst_rd_en", mem_rd_en, 32'd0);
        check("rst_valid", out_valid, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_err", rd_err, 32'd0);
`ifdef FIFO_RD_STATS_EN
        check("rst_wc", word_count, 32'd0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        #1;
        seg_start = rd_idx;
        wr_idx = rd_idx + pre;
        err_at = (err_k < 0) ? -1 : rd_idx + err_k;
        reads_n = 0;
        pops_n = 0;
        drops_base = drops_n;
        nRST = 1'b1;
        #1;
    endtask

    task automatic vr(input int pre, input int err_k, input logic en_i, input logic rdy_i);
        vec_t v;
        v = '{1'b1, pre, err_k, en_i, rdy_i, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs.push_back(v);
    endtask

    task automatic vc(input logic en_i, input logic rdy_i, input logic clr_i, input logic xr,
                      input logic xv, input logic [31:0] xd, input logic xe);
        vec_t v;
        v = '{1'b0, 0, -1, en_i, rdy_i, clr_i, xr, xv, xd, xe};
        vecs.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset(vecs[i].en, vecs[i].rdy, vecs[i].pre, vecs[i].err_k);
            end else begin
                tick(vecs[i].en, vecs[i].rdy, vecs[i].clr);
            end
            check($sformatf("%s[%0d].rd_en", tag, i), mem_rd_en, vecs[i].x_rd_en);
            check($sformatf("%s[%0d].valid", tag, i), out_valid, vecs[i].x_valid);
            if (vecs[i].x_valid) check($sformatf("%s[%0d].data", tag, i), out_data, vecs[i].x_data);
            check($sformatf("%s[%0d].rd_err", tag, i), rd_err, vecs[i].x_err);
        end
        vecs.delete();
    endtask

    // Accept n words in order starting at value first, within a cycle budget.
    task automatic drain(input string tag, input int n, input logic [31:0] first);
        int k = 0;
        for (int c = 0; c < 60 && k < n; c++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (out_valid) begin
                check($sformatf("%s.word%0d", tag, k), out_data, first + 32'(k));
                k++;
            end
        end
        check($sformatf("%s.count", tag), k, n);
        tick(1'b1, 1'b1, 1'b0);
        check($sformatf("%s.empty_after", tag), out_valid, 32'd0);
    endtask

    initial begin
        // Streaming: 5 words back to back, output from cycle 3 with no bubbles.
        vr(5, -1, 1'b1, 1'b1);
        vc(1, 1, 0, 1, 0, 32'h0, 0);
        vc(1, 1, 0, 1, 0, 32'h0, 0);
        vc(1, 1, 0, 1, 1, 32'hA0, 0);
        vc(1, 1, 0, 1, 1, 32'hA1, 0);
        vc(1, 1, 0, 1, 1, 32'hA2, 0);
        vc(1, 1, 0, 0, 1, 32'hA3, 0);
        vc(1, 1, 0, 0, 1, 32'hA4, 0);
        vc(1, 1, 0, 0, 0, 32'h0, 0);
        run_table("stream");

        // Consumer stall: three reads, head held at 0xA0, then drain all 8.
        vr(8, -1, 1'b1, 1'b0);
        vc(1, 0, 0, 1, 0, 32'h0, 0);
        vc(1, 0, 0, 1, 0, 32'h0, 0);
        vc(1, 0, 0, 1, 1, 32'hA0, 0);
        vc(1, 0, 0, 0, 1, 32'hA0, 0);
        vc(1, 0, 0, 0, 1, 32'hA0, 0);
        vc(1, 0, 0, 0, 1, 32'hA0, 0);
        run_table("stall");
        drain("stall_drain", 8, 32'hA0);
        check("stall_reads", reads_n, 32'd8);

        // Read error on the 2nd response: first word out, second dropped, sticky error.
        vr(2, 1, 1'b1, 1'b1);
        vc(1, 1, 0, 1, 0, 32'h0, 0);
        vc(1, 1, 0, 1, 0, 32'h0, 0);
        vc(1, 1, 0, 0, 1, 32'hA0, 0);
        vc(1, 1, 0, 0, 0, 32'h0, 1);
        run_table("err");
        wr_idx = wr_idx + 3;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b1, 1'b0);
            check("err_hold_rd_en", mem_rd_en, 32'd0);
            check("err_hold_flag", rd_err, 32'd1);
        end
        tick(1'b1, 1'b1, 1'b1);
        check("err_clr_cycle_flag", rd_err, 32'd1);
        tick(1'b1, 1'b1, 1'b0);
        check("err_cleared_flag", rd_err, 32'd0);
        check("err_idle_rd_en", mem_rd_en, 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        check("err_resume_rd_en", mem_rd_en, 32'd1);
        drain("err_resume", 3, 32'hA2);

        // en dropped during a read: the in-flight word still arrives, no more reads.
        vr(4, -1, 1'b1, 1'b1);
        vc(0, 1, 0, 1, 0, 32'h0, 0);
        vc(0, 1, 0, 0, 0, 32'h0, 0);
        vc(0, 1, 0, 0, 1, 32'hA0, 0);
        vc(0, 1, 0, 0, 0, 32'h0, 0);
        vc(0, 1, 0, 0, 0, 32'h0, 0);
        run_table("en_drop");

        // Reset with two buffered words and one read in flight: everything is lost.
        vr(8, -1, 1'b1, 1'b0);
        vc(1, 0, 0, 1, 0, 32'h0, 0);
        vc(1, 0, 0, 1, 0, 32'h0, 0);
        vc(1, 0, 0, 1, 1, 32'hA0, 0);
        vc(1, 0, 0, 0, 1, 32'hA0, 0);
        run_table("pre_rst");
        do_reset(1'b1, 1'b1, 0, -1);
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, 1'b1, 1'b0);
            check("post_rst_valid", out_valid, 32'd0);
            check("post_rst_rd_en", mem_rd_en, 32'd0);
        end

`ifdef FIFO_RD_STATS_EN
        // Counter wraps: 0x10001 deliveries leave word_count at 1.
        do_reset(1'b1, 1'b1, 65537, -1);
        for (int c = 0; c < 66000 && pops_n < 65537; c++) begin
            tick(1'b1, 1'b1, 1'b0);
        end
        check("stats_pops", pops_n, 32'd65537);
        tick(1'b1, 1'b1, 1'b0);
        check("stats_wc", word_count, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
